// File: rtl/comparator_max_tracker.sv
// Streaming max tracker: consumes 2-bit samples per frame and reports max, first index and length.
// Optional min tracking is enabled by defining COMPARATOR_MAX_TRACKER_MIN_EN.

module comparator_greater_than_structural (
    input  logic [1:0] a_i,
    input  logic [1:0] b_i,
    output logic       gt_o
);
    logic msb_gt;
    logic msb_eq;
    logic lsb_gt;

    assign msb_gt = a_i[1] & ~b_i[1];
    assign msb_eq = ~(a_i[1] ^ b_i[1]);
    assign lsb_gt = a_i[0] & ~b_i[0];
    assign gt_o   = msb_gt | (msb_eq & lsb_gt);
endmodule

module comparator_max_tracker #(
    parameter int FRAME_LEN = 8,
    parameter int IDX_W     = 3
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [1:0]       in_data_i,
    input  logic             in_last_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [1:0]       out_max_o,
    output logic [IDX_W-1:0] out_idx_o,
`ifdef COMPARATOR_MAX_TRACKER_MIN_EN
    output logic [1:0]       out_min_o,
    output logic [IDX_W-1:0] out_min_idx_o,
`endif
    output logic [IDX_W:0]   out_len_o
);
    // state | meaning
    // ACCUM | accepting samples of the current frame
    // HOLD  | frame result presented, waiting for consumer
    typedef enum logic {ACCUM = 1'b0, HOLD = 1'b1} state_t;

    localparam logic [IDX_W:0] LAST_CNT = (IDX_W+1)'(FRAME_LEN - 1);

    state_t           state_q;
    logic [IDX_W:0]   count_q;
    logic [1:0]       max_q, max_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [1:0]       out_max_q;
    logic [IDX_W-1:0] out_idx_q;
    logic [IDX_W:0]   out_len_q;
    logic             accept;
    logic             frame_end;
    logic             max_gt;

    assign in_ready_o  = (state_q == ACCUM);
    assign out_valid_o = (state_q == HOLD);
    assign accept      = in_valid_i & (state_q == ACCUM);
    assign frame_end   = in_last_i | (count_q == LAST_CNT);
    assign out_max_o   = out_max_q;
    assign out_idx_o   = out_idx_q;
    assign out_len_o   = out_len_q;

    comparator_greater_than_structural u_cmp_max (
        .a_i  (in_data_i),
        .b_i  (max_q),
        .gt_o (max_gt)
    );

    // First sample of a frame seeds the running value regardless of the comparator.
    always_comb begin
        max_d = max_q;
        idx_d = idx_q;
        if (count_q == '0) begin
            max_d = in_data_i;
            idx_d = '0;
        end else if (max_gt) begin
            max_d = in_data_i;
            idx_d = count_q[IDX_W-1:0];
        end
    end

`ifdef COMPARATOR_MAX_TRACKER_MIN_EN
    logic [1:0]       min_q, min_d;
    logic [IDX_W-1:0] min_idx_q, min_idx_d;
    logic [1:0]       out_min_q;
    logic [IDX_W-1:0] out_min_idx_q;
    logic             min_gt;

    assign out_min_o     = out_min_q;
    assign out_min_idx_o = out_min_idx_q;

    comparator_greater_than_structural u_cmp_min (
        .a_i  (min_q),
        .b_i  (in_data_i),
        .gt_o (min_gt)
    );

    always_comb begin
        min_d     = min_q;
        min_idx_d = min_idx_q;
        if (count_q == '0) begin
            min_d     = in_data_i;
            min_idx_d = '0;
        end else if (min_gt) begin
            min_d     = in_data_i;
            min_idx_d = count_q[IDX_W-1:0];
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            min_q         <= '0;
            min_idx_q     <= '0;
            out_min_q     <= '0;
            out_min_idx_q <= '0;
        end else if (accept) begin
            min_q     <= min_d;
            min_idx_q <= min_idx_d;
            if (frame_end) begin
                out_min_q     <= min_d;
                out_min_idx_q <= min_idx_d;
            end
        end
    end
`endif

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q   <= ACCUM;
            count_q   <= '0;
            max_q     <= '0;
            idx_q     <= '0;
            out_max_q <= '0;
            out_idx_q <= '0;
            out_len_q <= '0;
        end else begin
            case (state_q)
                ACCUM: begin
                    if (accept) begin
                        max_q   <= max_d;
                        idx_q   <= idx_d;
                        count_q <= count_q + 1'b1;
                        if (frame_end) begin
                            out_max_q <= max_d;
                            out_idx_q <= idx_d;
                            out_len_q <= count_q + 1'b1;
                            state_q   <= HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (out_ready_i) begin
                        count_q <= '0;
                        state_q <= ACCUM;
                    end
                end
                default: state_q <= ACCUM;
            endcase
        end
    end
endmodule

// File: tb/tb_comparator_max_tracker.sv
// Bench for comparator_max_tracker: queue-based frame model checked every cycle plus literal frame results.

module tb_comparator_max_tracker;
    localparam int FRAME_LEN = 4;
    localparam int IDX_W     = 2;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [1:0]       in_data = 2'd0;
    logic             in_last = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [1:0]       out_max;
    logic [IDX_W-1:0] out_idx;
    logic [IDX_W:0]   out_len;
`ifdef COMPARATOR_MAX_TRACKER_MIN_EN
    logic [1:0]       out_min;
    logic [IDX_W-1:0] out_min_idx;
`endif

    int checks = 0;
    int errors = 0;

    comparator_max_tracker #(.FRAME_LEN(FRAME_LEN), .IDX_W(IDX_W)) dut (
        .clk_i        (clk),
        .reset_i      (rst),
        .in_valid_i   (in_valid),
        .in_ready_o   (in_ready),
        .in_data_i    (in_data),
        .in_last_i    (in_last),
        .out_valid_o  (out_valid),
        .out_ready_i  (out_ready),
        .out_max_o    (out_max),
        .out_idx_o    (out_idx),
`ifdef COMPARATOR_MAX_TRACKER_MIN_EN
        .out_min_o    (out_min),
        .out_min_idx_o(out_min_idx),
`endif
        .out_len_o    (out_len)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    // Model: samples of the open frame, and the result pending for the consumer.
    int frm[$];
    bit busy = 1'b0;
    int e_max = 0, e_idx = 0, e_len = 0, e_min = 0, e_min_idx = 0;

    task automatic close_frame();
        int m, mn;
        bit found, found_min;
        m = 0;
        mn = 3;
        foreach (frm[i]) begin
            if (frm[i] > m) m = frm[i];
            if (frm[i] < mn) mn = frm[i];
        end
        found = 1'b0;
        found_min = 1'b0;
        foreach (frm[i]) begin
            if (!found && frm[i] == m) begin e_idx = i; found = 1'b1; end
            if (!found_min && frm[i] == mn) begin e_min_idx = i; found_min = 1'b1; end
        end
        e_max = m;
        e_min = mn;
        e_len = frm.size();
        frm.delete();
        busy = 1'b1;
    endtask

    initial begin
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                frm.delete();
                busy = 1'b0;
            end else if (!busy) begin
                if (in_valid) begin
                    frm.push_back(int'(in_data));
                    if (in_last || frm.size() == FRAME_LEN) close_frame();
                end
            end else if (out_ready) begin
                busy = 1'b0;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            check_eq("m_in_ready", int'(in_ready), int'(!busy));
            check_eq("m_out_valid", int'(out_valid), int'(busy));
            if (busy) begin
                check_eq("m_out_max", int'(out_max), e_max);
                check_eq("m_out_idx", int'(out_idx), e_idx);
                check_eq("m_out_len", int'(out_len), e_len);
`ifdef COMPARATOR_MAX_TRACKER_MIN_EN
                check_eq("m_out_min", int'(out_min), e_min);
                check_eq("m_out_min_idx", int'(out_min_idx), e_min_idx);
`endif
            end
        end
    end

    // Called at a negedge; returns at the negedge right after the sample is accepted.
    task automatic push(input logic [1:0] d, input logic last);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL push_timeout: got in_ready 0, expected 1");
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic wait_result(input string nm, input int m, input int idx, input int len);
        int n;
        n = 0;
        while (!out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check_eq({nm, "_latency"}, n, 0);
        check_eq({nm, "_max"}, int'(out_max), m);
        check_eq({nm, "_idx"}, int'(out_idx), idx);
        check_eq({nm, "_len"}, int'(out_len), len);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    initial begin
        #1 rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check_eq("rst_out_valid", int'(out_valid), 0);
        check_eq("rst_in_ready", int'(in_ready), 1);
        check_eq("rst_out_max", int'(out_max), 0);
        check_eq("rst_out_idx", int'(out_idx), 0);
        check_eq("rst_out_len", int'(out_len), 0);

        // Frame closed by length.
        push(2'd1, 1'b0); push(2'd2, 1'b0); push(2'd0, 1'b0); push(2'd3, 1'b0);
        in_valid = 1'b0;
        wait_result("basic", 3, 3, 4);

        // Ties keep the earliest index.
        push(2'd2, 1'b0); push(2'd2, 1'b0); push(2'd1, 1'b0); push(2'd2, 1'b0);
        in_valid = 1'b0;
        wait_result("ties", 2, 0, 4);

        // Early end via in_last.
        push(2'd0, 1'b0); push(2'd1, 1'b1);
        in_valid = 1'b0; in_last = 1'b0;
        wait_result("early", 1, 1, 2);

        // Single-sample frame.
        push(2'd2, 1'b1);
        in_valid = 1'b0; in_last = 1'b0;
        wait_result("single", 2, 0, 1);

        // Backpressure with in_valid held high during HOLD.
        push(2'd3, 1'b0); push(2'd0, 1'b0); push(2'd1, 1'b0); push(2'd2, 1'b0);
        in_data = 2'd1;
        for (int i = 0; i < 5; i++) begin
            check_eq("bp_out_valid", int'(out_valid), 1);
            check_eq("bp_in_ready", int'(in_ready), 0);
            check_eq("bp_out_max", int'(out_max), 3);
            @(negedge clk);
        end
        wait_result("bp", 3, 0, 4);
        check_eq("bp_bubble_ready", int'(in_ready), 1);
        @(posedge clk);
        @(negedge clk);
        push(2'd0, 1'b0); push(2'd3, 1'b0); push(2'd0, 1'b0);
        in_valid = 1'b0;
        wait_result("bp_next", 3, 2, 4);

        // Reset aborts a partial frame.
        push(2'd3, 1'b0); push(2'd3, 1'b0);
        in_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_eq("abort_out_valid", int'(out_valid), 0);
        check_eq("abort_in_ready", int'(in_ready), 1);
        push(2'd1, 1'b0); push(2'd0, 1'b0); push(2'd0, 1'b0); push(2'd0, 1'b0);
        in_valid = 1'b0;
        wait_result("abort_next", 1, 0, 4);

        // Max and min in the same frame.
        push(2'd2, 1'b0); push(2'd1, 1'b0); push(2'd3, 1'b0); push(2'd1, 1'b0);
        in_valid = 1'b0;
`ifdef COMPARATOR_MAX_TRACKER_MIN_EN
        check_eq("minmax_min", int'(out_min), 1);
        check_eq("minmax_min_idx", int'(out_min_idx), 1);
`endif
        wait_result("minmax", 3, 2, 4);

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got no completion, expected finish");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/comparator_max_tracker.md
Name: comparator_max_tracker

Overview:
Streaming downstream consumer of the team's 2-bit greater-than comparator (comparator_greater_than_structural).
- Accepts 2-bit samples over a valid/ready handshake.
- Tracks the running maximum and its index across a frame, then presents the frame result on a valid/ready output.
- Instantiates the comparator internally: A = incoming sample, B = current max.

Parameters:
FRAME_LEN, 8, maximum samples per frame; legal range 2..256.
IDX_W, 3, width of index/length fields; must equal clog2(FRAME_LEN), and for FRAME_LEN = 256 must be 8.

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset
in_valid  input  1  sample valid
in_ready  output  1  block can accept a sample
in_data  input  2  sample value
in_last  input  1  qualifies in_data as final sample of frame (early end)
out_valid  output  1  frame result valid
out_ready  input  1  consumer accepts result
out_max  output  2  maximum sample of frame
out_idx  output  IDX_W  index of first occurrence of out_max
out_len  output  IDX_W+1  number of samples in frame

Behaviour:
- Clocking and reset: one clock; reset is asynchronous and active-high. While reset is asserted, all input handshakes are ignored.
- Reset values: state=ACCUM, out_valid=0, out_max=0, out_idx=0, out_len=0, internal count=0. in_ready=1 once reset deasserts.
- FSM has two states:
  - ACCUM: in_ready=1, out_valid=0.
  - HOLD: in_ready=0, out_valid=1.
  - in_ready and out_valid decode from state only (Moore; no combinational in->out path).
- Accept in ACCUM = in_valid & in_ready at a rising clk.
  - count==0: max<=in_data, idx<=0.
  - otherwise: if comparator gt(in_data, max)=1 then max<=in_data, idx<=count; else hold.
  - Strict greater-than, so ties keep the earliest index.
  - count<=count+1 on every accept.
- Frame end is an accept with in_last=1 or count==FRAME_LEN-1.
  - out_max/out_idx take the post-update value; out_len<=count+1.
  - state->HOLD.
  - Latency: result valid on the cycle after the last sample is accepted.
- HOLD:
  - out_max/out_idx/out_len are stable.
  - in_valid is ignored; no sample is consumed.
  - On out_valid & out_ready: state->ACCUM, count<=0. in_ready returns the next cycle, so there is one bubble.
- Single-sample frames are legal: in_last on the first sample gives out_idx=0, out_len=1.
- Once max=3, no further update can occur; remaining samples are still consumed until frame end.
- Reset mid-frame or mid-HOLD discards the partial frame or pending result. No output is produced for it.
- out_len width IDX_W+1 holds FRAME_LEN exactly; count never wraps.

Optional Feature:
COMPARATOR_MAX_TRACKER_MIN_EN
- Defined:
  - Adds outputs out_min (2) and out_min_idx (IDX_W).
  - A second comparator instance computes gt(min, in_data); min updates on strict less-than, so ties keep the earliest index.
  - Same reset (0), same update timing and same hold rules as max.
- Undefined: neither port exists; no second comparator is instantiated.

Test Plan:
1. FRAME_LEN=4, samples 1,2,0,3 back-to-back, out_ready=1 -> out_valid 1 cycle after 4th accept; out_max=3, out_idx=3, out_len=4.
2. Ties: 2,2,1,2 -> out_max=2, out_idx=0, out_len=4.
3. Early end: 0, then 1 with in_last=1 -> out_max=1, out_idx=1, out_len=2; next frame starts with count=0.
4. Backpressure: frame 3,0,1,2 with out_ready=0 for 5 cycles and in_valid=1 held -> out_valid stays 1, outputs stable, in_ready=0, no sample consumed. After out_ready=1, the next frame's first accept occurs 1 cycle later.
5. Reset pulse after accepting 3,3, then frame 1,0,0,0 -> out_max=1, out_idx=0; no result emitted for the aborted frame.
6. With COMPARATOR_MAX_TRACKER_MIN_EN: 2,1,3,1 -> out_max=3/idx 2, out_min=1/out_min_idx=1.
